axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
AXI4-Lite responder that terminates transactions into a parameterised bank of read/write registers. It is the endpoint placed behind the width-adapter master port (m_axil_*) in peripheral subsystems. It exposes the register contents and per-register write pulses to user logic. Write and read channels operate independently and concurrently.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr in bits
DATA_WIDTH, 32, register and data-bus width; must be 32 or 64
REG_COUNT, 16, number of registers; power of two, 2..256
ADDR_LSB (localparam), log2(DATA_WIDTH/8), byte-offset bits ignored in decode

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
reg_out  out  REG_COUNT*DATA_WIDTH  flattened register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  REG_COUNT  one-cycle strobe per register on commit of an in-range write

Behaviour:
- Clock is clk. Reset is rstn: synchronous, active-low, sampled on the rising edge of clk.
- Reset state: all registers 0, reg_wr_pulse 0, bvalid/rvalid 0, bresp/rresp 2'b00, rdata 0.
- awready, wready and arready are registered. They are 0 during reset and go to 1 on the first edge with rstn high.
- Decode: index = addr[ADDR_LSB +: log2(REG_COUNT)]. Address is in range iff (addr >> ADDR_LSB) < REG_COUNT. Low ADDR_LSB bits are ignored.
- Write FSM states are W_IDLE and W_RESP.
  - In W_IDLE, AW and W are captured independently into holding registers.
  - awready drops after AW is captured. wready drops after W is captured.
  - On the edge where the second of AW/W is captured (or both in the same cycle):
    - an in-range write updates the register and pulses reg_wr_pulse[index] for exactly one cycle;
    - bvalid=1 and bresp=OKAY(00) for in range, DECERR(11) for out of range, with no register change;
    - FSM moves to W_RESP.
  - Latency: AW+W in the same cycle gives bvalid 1 cycle later.
- In W_RESP: awready=wready=0, bvalid held with stable bresp until bready. On the bvalid&bready edge: bvalid=0, awready=wready=1, FSM returns to W_IDLE. Back-to-back throughput is one write per 2 cycles.
- Read FSM states are R_IDLE and R_DATA.
  - In R_IDLE, arready=1. On arvalid&arready: rdata = register[index] and rresp=OKAY for in range; rdata=0 and rresp=DECERR out of range. Then rvalid=1, arready=0, FSM to R_DATA.
  - In R_DATA, rdata/rresp are held stable until rready. On that handshake: rvalid=0, arready=1.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- valid signals never depend combinationally on ready. Outputs hold while stalled.
- Reset mid-transaction: holding registers, pending responses and registers are all cleared. No response is issued for an aborted transaction.

Optional Feature:
AXIL_REG_STRB_EN
- Defined: adds port s_axil_wstrb  in  DATA_WIDTH/8, captured with W. Only byte lanes with their strobe bit set are updated. reg_wr_pulse fires for an in-range write even when wstrb=0. DECERR handling is unchanged.
- Undefined: no wstrb port; every write updates the full word.

Decomposition:
- Package axil_pkg:
  - response constants AXIL_RESP_OKAY=2'b00, AXIL_RESP_SLVERR=2'b10, AXIL_RESP_DECERR=2'b11;
  - write FSM enum {W_IDLE, W_RESP} and read FSM enum {R_IDLE, R_DATA};
  - clog2-style helper for ADDR_LSB and the index width.
- Sub-module axil_reg_bank: storage array, byte-strobe merge, reg_wr_pulse generation, combinational read mux. The top module holds both handshake FSMs.

Test Plan:
- AW and W in the same cycle, awaddr=0x08, wdata=0xDEADBEEF, bready=1 -> bvalid 1 cycle later with bresp=00; reg_wr_pulse[2] high for one cycle; reg_out[95:64]=0xDEADBEEF.
- W leads AW by 3 cycles (awaddr=0x04, wdata=0x12345678) -> wready low after W capture; commit and bvalid on the cycle after AW is accepted; register 1=0x12345678.
- Out-of-range write (awaddr=0x40, REG_COUNT=16) followed by a read of 0x40 -> bresp=11 with no reg_wr_pulse; rresp=11 and rdata=0; all registers unchanged.
- Response backpressure: bready=0 for 5 cycles and rready=0 for 4 cycles -> bvalid/rvalid and their data held stable; awready, wready and arready stay 0 until the handshake completes.
- Read of register 3 on the same edge as a write commit of 0xA5A5A5A5 to register 3 (prior value 0x11) -> rdata=0x11; a subsequent read returns 0xA5A5A5A5.
- With AXIL_REG_STRB_EN defined, write 0xFFFFFFFF with wstrb=4'b0101 to a register holding 0 -> reg=0x00FF00FF. Separately, rstn low for 1 cycle while bvalid is pending -> bvalid=0, all registers 0, awready=1 on the next cycle.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and the debug state view
// used by the register responder.
package axil_pkg;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE, W_RESP} axil_wstate_e;
   typedef enum logic {R_IDLE, R_DATA} axil_rstate_e;

   typedef struct packed {
      axil_wstate_e wstate;
      logic         aw_held;
      logic         w_held;
      axil_rstate_e rstate;
   } axil_dbg_t;

   // Smallest n with 2**n >= value; evaluated at elaboration for widths.
   function automatic int axil_clog2(input int value);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for axil_reg_slave: byte-lane merge on write, one-cycle
// write strobes and an asynchronous read mux.
module axil_reg_bank
   import axil_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int REG_COUNT  = 16,
   localparam int IDX_W      = axil_clog2(REG_COUNT),
   localparam int STRB_W     = DATA_WIDTH / 8
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            i_we,
   input  logic [IDX_W-1:0]                i_widx,
   input  logic [DATA_WIDTH-1:0]           i_wdata,
   input  logic [STRB_W-1:0]               i_wstrb,
   input  logic [IDX_W-1:0]                i_ridx,
   output logic [DATA_WIDTH-1:0]           o_rdata,
   output logic [REG_COUNT*DATA_WIDTH-1:0] o_regs,
   output logic [REG_COUNT-1:0]            o_wr_pulse
);

   logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
   logic [REG_COUNT-1:0]  r_wr_pulse;

   // The pulse fires on any committed in-range write, even with no lanes enabled.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (i_we) begin
            r_wr_pulse[i_widx] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
               if (i_wstrb[b]) r_regs[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign o_rdata    = r_regs[i_ridx];
   assign o_wr_pulse = r_wr_pulse;

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
      assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
   end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder terminating into a register bank; independent write and
// read FSMs. Define AXIL_REG_STRB_EN to add s_axil_wstrb byte-lane writes.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 16
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
   input  logic                            s_axil_awvalid,
   output logic                            s_axil_awready,
   input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
`ifdef AXIL_REG_STRB_EN
   input  logic [DATA_WIDTH/8-1:0]         s_axil_wstrb,
`endif
   input  logic                            s_axil_wvalid,
   output logic                            s_axil_wready,
   output logic [1:0]                      s_axil_bresp,
   output logic                            s_axil_bvalid,
   input  logic                            s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
   input  logic                            s_axil_arvalid,
   output logic                            s_axil_arready,
   output logic [DATA_WIDTH-1:0]           s_axil_rdata,
   output logic [1:0]                      s_axil_rresp,
   output logic                            s_axil_rvalid,
   input  logic                            s_axil_rready,
   output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
   output logic [REG_COUNT-1:0]            reg_wr_pulse,
   output axil_dbg_t                       dbg_state
);

   localparam int ADDR_LSB = axil_clog2(DATA_WIDTH / 8);
   localparam int IDX_W    = axil_clog2(REG_COUNT);
   localparam int STRB_W   = DATA_WIDTH / 8;

   // Handshake: a beat transfers on a rising edge where valid and ready are both
   // high; every ready/valid here is a register, never a function of the peer's.

   axil_wstate_e          r_wstate;
   logic                  r_aw_held, r_w_held;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_awready, r_wready, r_bvalid;
   logic [1:0]            r_bresp;
   axil_rstate_e          r_rstate;
   logic                  r_arready, r_rvalid;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_aw_fire, w_w_fire, w_ar_fire, w_commit, w_we;
   logic                  w_wr_in_range, w_rd_in_range;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data, w_bank_rdata;
   logic [STRB_W-1:0]     w_wr_strb;

   assign w_aw_fire = s_axil_awvalid & r_awready;
   assign w_w_fire  = s_axil_wvalid & r_wready;
   assign w_ar_fire = s_axil_arvalid & r_arready;

   // Whichever half arrives last is taken straight from the bus on the commit edge.
   assign w_wr_addr = r_aw_held ? r_awaddr : s_axil_awaddr;
   assign w_wr_data = r_w_held  ? r_wdata  : s_axil_wdata;
`ifdef AXIL_REG_STRB_EN
   logic [STRB_W-1:0] r_wstrb;
   assign w_wr_strb = r_w_held ? r_wstrb : s_axil_wstrb;
`else
   assign w_wr_strb = '1;
`endif

   assign w_commit      = (r_wstate == W_IDLE) & (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
   assign w_wr_in_range = (w_wr_addr >> ADDR_LSB) < ADDR_WIDTH'(REG_COUNT);
   assign w_rd_in_range = (s_axil_araddr >> ADDR_LSB) < ADDR_WIDTH'(REG_COUNT);
   assign w_we          = w_commit & w_wr_in_range;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wstate  <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
`ifdef AXIL_REG_STRB_EN
         r_wstrb   <= '0;
`endif
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXIL_RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_commit) begin
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
                  r_wstate  <= W_RESP;
               end else begin
                  if (w_aw_fire) begin
                     r_aw_held <= 1'b1;
                     r_awaddr  <= s_axil_awaddr;
                  end
                  if (w_w_fire) begin
                     r_w_held <= 1'b1;
                     r_wdata  <= s_axil_wdata;
`ifdef AXIL_REG_STRB_EN
                     r_wstrb  <= s_axil_wstrb;
`endif
                  end
                  r_awready <= ~(r_aw_held | w_aw_fire);
                  r_wready  <= ~(r_w_held | w_w_fire);
               end
            end
            W_RESP: begin
               if (r_bvalid & s_axil_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
         endcase
      end
   end

   // The bank mux sees pre-edge contents, so a colliding read returns the old value.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= AXIL_RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_fire) begin
                  r_rdata   <= w_rd_in_range ? w_bank_rdata : '0;
                  r_rresp   <= w_rd_in_range ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_rvalid & s_axil_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
         endcase
      end
   end

   axil_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT)
   ) u_bank (
      .clk        (clk),
      .rstn       (rstn),
      .i_we       (w_we),
      .i_widx     (w_wr_addr[ADDR_LSB +: IDX_W]),
      .i_wdata    (w_wr_data),
      .i_wstrb    (w_wr_strb),
      .i_ridx     (s_axil_araddr[ADDR_LSB +: IDX_W]),
      .o_rdata    (w_bank_rdata),
      .o_regs     (reg_out),
      .o_wr_pulse (reg_wr_pulse)
   );

   assign s_axil_awready = r_awready;
   assign s_axil_wready  = r_wready;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_arready = r_arready;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rresp   = r_rresp;
   assign s_axil_rdata   = r_rdata;

   assign dbg_state = '{wstate: r_wstate, aw_held: r_aw_held, w_held: r_w_held, rstate: r_rstate};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed vector table, hand-built corner sequences
// and random traffic checked against an array model of the register file.
module tb_axil_reg_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RC = 16;

   logic              clk = 1'b0;
   logic              rstn;
   logic [AW-1:0]     s_axil_awaddr, s_axil_araddr;
   logic              s_axil_awvalid, s_axil_awready;
   logic [DW-1:0]     s_axil_wdata, s_axil_rdata;
`ifdef AXIL_REG_STRB_EN
   logic [DW/8-1:0]   s_axil_wstrb;
`endif
   logic              s_axil_wvalid, s_axil_wready;
   logic [1:0]        s_axil_bresp, s_axil_rresp;
   logic              s_axil_bvalid, s_axil_bready;
   logic              s_axil_arvalid, s_axil_arready;
   logic              s_axil_rvalid, s_axil_rready;
   logic [RC*DW-1:0]  reg_out;
   logic [RC-1:0]     reg_wr_pulse;
   axil_pkg::axil_dbg_t dbg_state;

   axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
      .clk(clk), .rstn(rstn),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata),
`ifdef AXIL_REG_STRB_EN
      .s_axil_wstrb(s_axil_wstrb),
`endif
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready),
      .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] model [RC];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          aw_dly;
      int          w_dly;
      int          b_stall;
      int          r_stall;
      logic [1:0]  exp_bresp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string name);
      logic [RC*DW-1:0] exp;
      for (int i = 0; i < RC; i++) exp[i*DW +: DW] = model[i];
      n_checks++;
      if (reg_out !== exp) begin
         n_errors++;
         $display("FAIL %s: reg_out=%h expected %h", name, reg_out, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a / 4) < RC;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [3:0] s;
      int         idx;
`ifdef AXIL_REG_STRB_EN
      s = strb;
`else
      s = 4'hF;
`endif
      if (in_range(addr)) begin
         idx = int'(addr / 4);
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall, output logic [1:0] resp);
      int            cyc;
      bit            aw_done, w_done, aw_now, w_now;
      logic [RC-1:0] exp_pulse;
      logic [1:0]    exp_resp;
      aw_done   = 0;
      w_done    = 0;
      cyc       = 0;
      resp      = 2'bxx;
      exp_resp  = in_range(addr) ? 2'b00 : 2'b11;
      exp_pulse = in_range(addr) ? (RC'(1) << (addr / 4)) : '0;
      s_axil_awaddr = addr;
      s_axil_wdata  = data;
`ifdef AXIL_REG_STRB_EN
      s_axil_wstrb  = strb;
`endif
      s_axil_bready = 1'b0;
      while (!(aw_done && w_done) && cyc < 40) begin
         s_axil_awvalid = !aw_done && (cyc >= aw_dly);
         s_axil_wvalid  = !w_done && (cyc >= w_dly);
         aw_now = s_axil_awvalid && s_axil_awready;
         w_now  = s_axil_wvalid && s_axil_wready;
         @(posedge clk); #1;
         if (aw_now) aw_done = 1;
         if (w_now)  w_done = 1;
         if (w_done && !aw_done) check("wready_low_after_w", s_axil_wready, 0);
         if (aw_done && !w_done) check("awready_low_after_aw", s_axil_awready, 0);
         cyc++;
      end
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         check("write_handshake_timeout", 0, 1);
         return;
      end
      model_write(addr, data, strb);
      check("bvalid_after_commit", s_axil_bvalid, 1);
      check("bresp", s_axil_bresp, exp_resp);
      check("wr_pulse", reg_wr_pulse, exp_pulse);
      check("awready_in_resp", s_axil_awready, 0);
      check("wready_in_resp", s_axil_wready, 0);
      check_regs("regs_after_write");
      resp = s_axil_bresp;
      for (int i = 0; i < b_stall; i++) begin
         @(posedge clk); #1;
         check("bvalid_hold", s_axil_bvalid, 1);
         check("bresp_hold", s_axil_bresp, resp);
         check("awready_stall", s_axil_awready, 0);
         check("wready_stall", s_axil_wready, 0);
         check("wr_pulse_once", reg_wr_pulse, 0);
      end
      s_axil_bready = 1'b1;
      @(posedge clk); #1;
      s_axil_bready = 1'b0;
      check("bvalid_clear", s_axil_bvalid, 0);
      check("awready_back", s_axil_awready, 1);
      check("wready_back", s_axil_wready, 1);
      check("wr_pulse_done", reg_wr_pulse, 0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_stall,
                          output logic [31:0] data, output logic [1:0] resp);
      int  cyc;
      bit  done, now;
      done = 0;
      cyc  = 0;
      data = 'x;
      resp = 2'bxx;
      s_axil_araddr = addr;
      s_axil_rready = 1'b0;
      while (!done && cyc < 40) begin
         s_axil_arvalid = (cyc >= ar_dly);
         now = s_axil_arvalid && s_axil_arready;
         @(posedge clk); #1;
         if (now) done = 1;
         cyc++;
      end
      s_axil_arvalid = 1'b0;
      if (!done) begin
         check("read_handshake_timeout", 0, 1);
         return;
      end
      check("rvalid_after_ar", s_axil_rvalid, 1);
      check("arready_low", s_axil_arready, 0);
      check("rdata_model", s_axil_rdata, in_range(addr) ? model[int'(addr / 4)] : 32'h0);
      check("rresp_model", s_axil_rresp, in_range(addr) ? 2'b00 : 2'b11);
      data = s_axil_rdata;
      resp = s_axil_rresp;
      for (int i = 0; i < r_stall; i++) begin
         @(posedge clk); #1;
         check("rvalid_hold", s_axil_rvalid, 1);
         check("rdata_hold", s_axil_rdata, data);
         check("rresp_hold", s_axil_rresp, resp);
         check("arready_stall", s_axil_arready, 0);
      end
      s_axil_rready = 1'b1;
      @(posedge clk); #1;
      s_axil_rready = 1'b0;
      check("rvalid_clear", s_axil_rvalid, 0);
      check("arready_back", s_axil_arready, 1);
   endtask

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      logic [31:0] addr;

      //                 addr          data          awd wd bst rst bresp  rdata          rresp
      vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{32'h0000_0004, 32'h1234_5678, 3, 0, 0, 0, 2'b00, 32'h1234_5678, 2'b00};
      vecs[2] = '{32'h0000_0040, 32'hCAFE_F00D, 0, 0, 0, 0, 2'b11, 32'h0000_0000, 2'b11};
      vecs[3] = '{32'h0000_0014, 32'h0BAD_F00D, 0, 0, 5, 4, 2'b00, 32'h0BAD_F00D, 2'b00};
      vecs[4] = '{32'h0000_003C, 32'h5A5A_0001, 0, 2, 1, 1, 2'b00, 32'h5A5A_0001, 2'b00};
      vecs[5] = '{32'h0000_000B, 32'h0000_00AA, 1, 1, 0, 2, 2'b00, 32'h0000_00AA, 2'b00};
      vecs[6] = '{32'h0000_1000, 32'hFFFF_FFFF, 0, 0, 2, 0, 2'b11, 32'h0000_0000, 2'b11};
      vecs[7] = '{32'h0000_000C, 32'h0000_0011, 0, 0, 0, 0, 2'b00, 32'h0000_0011, 2'b00};

      for (int i = 0; i < RC; i++) model[i] = '0;
      rstn = 1'b0;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
      s_axil_wdata = '0;  s_axil_wvalid = 1'b0;
`ifdef AXIL_REG_STRB_EN
      s_axil_wstrb = '1;
`endif
      s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0;
      s_axil_rready = 1'b0;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", s_axil_awready, 0);
      check("rst_wready", s_axil_wready, 0);
      check("rst_arready", s_axil_arready, 0);
      check("rst_bvalid", s_axil_bvalid, 0);
      check("rst_rvalid", s_axil_rvalid, 0);
      check("rst_bresp", s_axil_bresp, 0);
      check("rst_rresp", s_axil_rresp, 0);
      check("rst_rdata", s_axil_rdata, 0);
      check("rst_pulse", reg_wr_pulse, 0);
      check_regs("rst_regs");
      rstn = 1'b1;
      @(posedge clk); #1;
      check("post_rst_awready", s_axil_awready, 1);
      check("post_rst_wready", s_axil_wready, 1);
      check("post_rst_arready", s_axil_arready, 1);

      // Directed vector table: write then read back.
      foreach (vecs[i]) begin
         do_write(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_stall, resp);
         check("tbl_bresp", resp, vecs[i].exp_bresp);
         if (vecs[i].exp_bresp == 2'b00)
            check("tbl_reg_out_slice", reg_out[(vecs[i].addr / 4) * DW +: DW], vecs[i].data);
         do_read(vecs[i].addr, 0, vecs[i].r_stall, rdata, rresp);
         check("tbl_rdata", rdata, vecs[i].exp_rdata);
         check("tbl_rresp", rresp, vecs[i].exp_rresp);
      end

      // Read and write commit to register 3 on the same edge (reg3 holds 0x11).
      s_axil_awaddr = 32'h0C; s_axil_wdata = 32'hA5A5_A5A5;
`ifdef AXIL_REG_STRB_EN
      s_axil_wstrb = '1;
`endif
      s_axil_araddr = 32'h0C;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
      check("coll_ready_aw", s_axil_awready, 1);
      check("coll_ready_ar", s_axil_arready, 1);
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
      check("coll_rvalid", s_axil_rvalid, 1);
      check("coll_rdata_old", s_axil_rdata, 32'h0000_0011);
      check("coll_bvalid", s_axil_bvalid, 1);
      check("coll_pulse", reg_wr_pulse, 16'h0008);
      model[3] = 32'hA5A5_A5A5;
      s_axil_bready = 1'b1; s_axil_rready = 1'b1;
      @(posedge clk); #1;
      s_axil_bready = 1'b0; s_axil_rready = 1'b0;
      check("coll_bvalid_clr", s_axil_bvalid, 0);
      check("coll_rvalid_clr", s_axil_rvalid, 0);
      do_read(32'h0C, 0, 0, rdata, rresp);
      check("coll_rdata_new", rdata, 32'hA5A5_A5A5);

`ifdef AXIL_REG_STRB_EN
      do_write(32'h18, 32'h0, 4'hF, 0, 0, 0, resp);
      do_write(32'h18, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, resp);
      check("strb_merge", reg_out[6*DW +: DW], 32'h00FF_00FF);
      do_write(32'h18, 32'h1234_5678, 4'b0000, 1, 0, 0, resp);
      check("strb_none", reg_out[6*DW +: DW], 32'h00FF_00FF);
`endif

      // Reset while a write response is pending.
      s_axil_awaddr = 32'h10; s_axil_wdata = 32'h77;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("midrst_bvalid_pending", s_axil_bvalid, 1);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      for (int i = 0; i < RC; i++) model[i] = '0;
      check("midrst_bvalid", s_axil_bvalid, 0);
      check("midrst_awready_in_rst", s_axil_awready, 0);
      check_regs("midrst_regs");
      @(posedge clk); #1;
      check("midrst_awready", s_axil_awready, 1);
      check("midrst_wready", s_axil_wready, 1);
      check("midrst_arready", s_axil_arready, 1);
      check("midrst_no_bvalid", s_axil_bvalid, 0);

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         addr = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
            check("rnd_bresp", resp, in_range(addr) ? 2'b00 : 2'b11);
         end else begin
            do_read(addr, $urandom_range(0, 2), $urandom_range(0, 3), rdata, rresp);
         end
      end
      check_regs("final_regs");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
